hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 156 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Tracks in-flight destination registers of the stages behind ID
//             (EX, MEM, WB, ...). It selects a forwarding source for each of
//             the two ID source operands and raises a stall for load-use
//             hazards whose result cannot be forwarded yet. It also keeps a
//             saturating count of stalled cycles.
//  Ports    : clk          - clock, rising edge
//             arst_n       - asynchronous active-low reset
//             enable       - global advance; low freezes all state
//             issue_valid  - instruction in ID requests issue
//             issue_rd     - destination register of the issuing instruction
//             issue_we     - issuing instruction writes issue_rd
//             issue_load   - issuing instruction is a load
//             issue_rs/rt  - source registers of the instruction in ID
//             use_rs/rt    - the corresponding source is actually read
//             flush        - taken branch/jump; squash the young stages
//             stall        - ID must hold; a bubble is inserted
//             fwd_rs/rt    - 0 = register file, k+1 = forward from stage k
//             stall_cnt    - saturating count of stalled enabled cycles
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_AVAIL  = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16,
    // Derived forwarding-select width; leave at its default.
    parameter int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_we,
    input  logic              issue_load,
    input  logic [ADDR_W-1:0] issue_rs,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs,
    output logic [SEL_W-1:0]  fwd_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // In-flight entries; index 0 is the youngest stage (EX).
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_we;
    logic [DEPTH-1:0]  r_load;
    logic [ADDR_W-1:0] r_rd [DEPTH];
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [DEPTH-1:0]  w_nxt_valid;
    logic [DEPTH-1:0]  w_nxt_we;
    logic [DEPTH-1:0]  w_nxt_load;
    logic [ADDR_W-1:0] w_nxt_rd [DEPTH];

    logic              w_rs_block;
    logic              w_rt_block;
    logic [SEL_W-1:0]  w_fwd_rs;
    logic [SEL_W-1:0]  w_fwd_rt;
    logic              w_stall;

    // ------------------------------------------------------------------------
    // Operand match. The scan runs oldest to youngest so the youngest
    // producer overwrites any older one. A load at a stage below LOAD_AVAIL
    // has no result yet and blocks instead of forwarding. Register 0 never
    // matches because it is hard-wired.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rs_block = 1'b0;
        w_rt_block = 1'b0;
        w_fwd_rs   = '0;
        w_fwd_rt   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_rs && (issue_rs != '0) && r_valid[k] && r_we[k] &&
                (r_rd[k] == issue_rs)) begin
                w_rs_block = r_load[k] && (k < LOAD_AVAIL);
                w_fwd_rs   = w_rs_block ? '0 : SEL_W'(k + 1);
            end
            if (use_rt && (issue_rt != '0) && r_valid[k] && r_we[k] &&
                (r_rd[k] == issue_rt)) begin
                w_rt_block = r_load[k] && (k < LOAD_AVAIL);
                w_fwd_rt   = w_rt_block ? '0 : SEL_W'(k + 1);
            end
        end
    end

    // A flush squashes the instruction in ID, so there is nothing to hold.
    assign w_stall = issue_valid && !flush && (w_rs_block || w_rt_block);

    // ------------------------------------------------------------------------
    // Next entry state: shift by one stage. Stage 0 takes the issuing
    // instruction or a bubble. The youngest FLUSH_DEPTH stages are squashed
    // after the shift when a flush is taken.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nxt_valid[0] = issue_valid && !w_stall && !flush;
        w_nxt_we[0]    = issue_we;
        w_nxt_load[0]  = issue_load;
        w_nxt_rd[0]    = issue_rd;
        for (int k = 1; k < DEPTH; k++) begin
            w_nxt_valid[k] = r_valid[k-1] && !(flush && (k < FLUSH_DEPTH));
            w_nxt_we[k]    = r_we[k-1];
            w_nxt_load[k]  = r_load[k-1];
            w_nxt_rd[k]    = r_rd[k-1];
        end
    end

    // ------------------------------------------------------------------------
    // State registers. While enable is low, all state holds, including the
    // counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid <= '0;
            r_we    <= '0;
            r_load  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else if (enable) begin
            r_valid <= w_nxt_valid;
            r_we    <= w_nxt_we;
            r_load  <= w_nxt_load;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= w_nxt_rd[k];
            end
        end
    end

    // The stall counter saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= '0;
        end else if (enable && w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall     = w_stall;
    assign fwd_rs    = w_fwd_rs;
    assign fwd_rt    = w_fwd_rt;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Directed self-checking bench for hazard_scoreboard. It drives a
//             default-parameter instance and a CNT_W=2 instance from the same
//             stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk;
    logic       arst_n;
    logic       enable;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_we;
    logic       issue_load;
    logic [4:0] issue_rs;
    logic [4:0] issue_rt;
    logic       use_rs;
    logic       use_rt;
    logic       flush;

    logic        stall;
    logic [1:0]  fwd_rs;
    logic [1:0]  fwd_rt;
    logic [15:0] stall_cnt;

    logic        stall_s;
    logic [1:0]  fwd_rs_s;
    logic [1:0]  fwd_rt_s;
    logic [1:0]  stall_cnt_s;

    int vectors;
    int miscompares;

    hazard_scoreboard u_dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .enable     (enable),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_we   (issue_we),
        .issue_load (issue_load),
        .issue_rs   (issue_rs),
        .issue_rt   (issue_rt),
        .use_rs     (use_rs),
        .use_rt     (use_rt),
        .flush      (flush),
        .stall      (stall),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .stall_cnt  (stall_cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) u_sat (
        .clk        (clk),
        .arst_n     (arst_n),
        .enable     (enable),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_we   (issue_we),
        .issue_load (issue_load),
        .issue_rs   (issue_rs),
        .issue_rt   (issue_rt),
        .use_rs     (use_rs),
        .use_rt     (use_rt),
        .flush      (flush),
        .stall      (stall_s),
        .fwd_rs     (fwd_rs_s),
        .fwd_rt     (fwd_rt_s),
        .stall_cnt  (stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int v, input int rd, input int we, input int ld,
                         input int rs, input int urs, input int rt, input int urt,
                         input int fl);
        issue_valid = (v != 0);
        issue_rd    = 5'(rd);
        issue_we    = (we != 0);
        issue_load  = (ld != 0);
        issue_rs    = 5'(rs);
        use_rs      = (urs != 0);
        issue_rt    = 5'(rt);
        use_rt      = (urt != 0);
        flush       = (fl != 0);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        arst_n      = 1'b0;
        enable      = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("reset_stall",   32'(stall),       0);
        check("reset_fwd_rs",  32'(fwd_rs),      0);
        check("reset_fwd_rt",  32'(fwd_rt),      0);
        check("reset_cnt",     32'(stall_cnt),   0);
        check("reset_cnt_sat", 32'(stall_cnt_s), 0);
        arst_n = 1'b1;
        enable = 1'b1;
        tick();

        // ALU back-to-back forwarding from EX, MEM and WB.
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        check("alu_issue_stall", 32'(stall), 0);
        tick();
        drive(1, 9, 0, 0, 3, 1, 0, 0, 0);
        check("alu_b2b_stall", 32'(stall), 0);
        check("alu_b2b_fwd_rs", 32'(fwd_rs), 1);
        tick();
        drive(1, 9, 0, 0, 0, 0, 3, 1, 0);
        check("alu_mem_fwd_rt", 32'(fwd_rt), 2);
        check("alu_mem_fwd_rs_unused", 32'(fwd_rs), 0);
        tick();
        drive(1, 9, 0, 0, 3, 1, 0, 0, 0);
        check("alu_wb_fwd_rs", 32'(fwd_rs), 3);
        tick();

        // Load-use: one stall cycle, then forward from MEM.
        drive(1, 5, 1, 1, 0, 0, 0, 0, 0);
        check("load_issue_stall", 32'(stall), 0);
        tick();
        drive(1, 10, 1, 0, 5, 1, 0, 0, 0);
        check("loaduse_stall", 32'(stall), 1);
        check("loaduse_cnt_before", 32'(stall_cnt), 0);
        tick();
        check("loaduse_release_stall", 32'(stall), 0);
        check("loaduse_fwd_rs", 32'(fwd_rs), 2);
        check("loaduse_cnt", 32'(stall_cnt), 1);
        tick();

        // Youngest producer wins; unused source and r0 never match.
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 4, 1, 0, 0, 0);
        check("youngest_fwd_rs", 32'(fwd_rs), 1);
        check("youngest_stall", 32'(stall), 0);
        drive(0, 0, 0, 0, 4, 0, 0, 0, 0);
        check("unused_rs_fwd", 32'(fwd_rs), 0);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 4, 1, 0);
        check("r0_fwd_rs", 32'(fwd_rs), 0);
        check("r4_behind_r0_fwd_rt", 32'(fwd_rt), 2);
        drive(1, 4, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 12, 0, 0, 4, 1, 0, 0, 0);
        check("young_load_over_old_alu_stall", 32'(stall), 1);
        drive(0, 0, 0, 0, 4, 1, 0, 0, 0);
        check("no_issue_no_stall", 32'(stall), 0);
        tick();

        // Flush drops the issuing producer; flush beats a load-use stall.
        drive(1, 7, 1, 0, 0, 0, 0, 0, 1);
        check("flush_issue_stall", 32'(stall), 0);
        tick();
        drive(1, 13, 0, 0, 7, 1, 0, 0, 0);
        check("flushed_fwd_rs", 32'(fwd_rs), 0);
        check("flushed_stall", 32'(stall), 0);
        tick();
        drive(1, 6, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 14, 1, 0, 6, 1, 0, 0, 1);
        check("flush_over_stall", 32'(stall), 0);
        tick();
        drive(1, 15, 0, 0, 6, 1, 0, 0, 0);
        check("load_survives_flush_stall", 32'(stall), 0);
        check("load_survives_flush_fwd", 32'(fwd_rs), 2);
        check("flush_cnt_unchanged", 32'(stall_cnt), 1);
        tick();

        // Freeze for 3 cycles during a load-use stall.
        drive(1, 5, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 9, 0, 0, 5, 1, 0, 0, 0);
        check("freeze_pre_stall", 32'(stall), 1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_stall", 32'(stall), 1);
            check("freeze_cnt", 32'(stall_cnt), 1);
        end
        enable = 1'b1;
        tick();
        check("unfreeze_stall", 32'(stall), 0);
        check("unfreeze_fwd_rs", 32'(fwd_rs), 2);
        check("unfreeze_cnt", 32'(stall_cnt), 2);
        check("unfreeze_cnt_sat", 32'(stall_cnt_s), 2);
        tick();

        // Asynchronous reset with three valid entries.
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 3, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 9, 0, 0, 3, 1, 2, 1, 0);
        check("full_stall", 32'(stall), 1);
        check("full_fwd_rt", 32'(fwd_rt), 2);
        drive(0, 0, 0, 0, 1, 1, 2, 1, 0);
        check("full_fwd_rs_wb", 32'(fwd_rs), 3);
        drive(1, 9, 0, 0, 3, 1, 2, 1, 0);
        arst_n = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 0);
        check("arst_fwd_rt", 32'(fwd_rt), 0);
        check("arst_cnt", 32'(stall_cnt), 0);
        check("arst_cnt_sat", 32'(stall_cnt_s), 0);
        drive(1, 9, 0, 0, 1, 1, 2, 1, 0);
        check("arst_fwd_rs", 32'(fwd_rs), 0);
        arst_n = 1'b1;
        drive(1, 11, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 11, 1, 3, 1, 0);
        check("post_reset_fwd_rs", 32'(fwd_rs), 1);
        check("post_reset_fwd_rt", 32'(fwd_rt), 0);
        check("post_reset_stall", 32'(stall), 0);

        // Four load-use pairs: the 2-bit counter saturates at 3.
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 1, 1, 0, 0, 0, 0, 0);
            tick();
            drive(1, 9, 0, 0, 5, 1, 0, 0, 0);
            check("sat_pair_stall", 32'(stall), 1);
            tick();
            check("sat_pair_release", 32'(stall), 0);
            check("sat_cnt_wide", 32'(stall_cnt), i + 1);
            check("sat_cnt_narrow", 32'(stall_cnt_s), (i + 1 > 3) ? 3 : i + 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
